wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter CLEAR_VALUE, default 32'h0000_0000: value written to x1..x31 during the post-reset clear sequence.
REQ-002 Ports, in order, with direction, width and meaning:
  - clock  in  1: single clock; all state changes on the rising edge.
  - reset  in  1: synchronous, active-high reset.
  - alu_valid  in  1: ALU writeback request.
  - alu_rd  in  5: ALU destination register.
  - alu_data  in  32: ALU result.
  - alu_ready  out  1: ALU request accepted this cycle; combinational.
  - mem_valid  in  1: load writeback request.
  - mem_rd  in  5: load destination register.
  - mem_data  in  32: load data.
  - mem_ready  out  1: load request accepted this cycle; combinational.
  - rf_we  out  1: register-file write enable; registered.
  - rf_rd  out  5: register-file write index; registered.
  - rf_inf  out  32: register-file write data; registered.
  - init_done  out  1: clear sequence finished; registered.
REQ-003 One clock; reset is synchronous and active-high; the ports are named clock and reset.

Function
REQ-004 The block SHALL implement two states: CLEAR and RUN, plus a 5-bit clear counter cnt.
REQ-005 In CLEAR, each cycle SHALL drive, at the next edge, rf_we=1, rf_rd=cnt and rf_inf=(cnt==0 ? 0 : CLEAR_VALUE), then increment cnt.
REQ-006 The edge that issues cnt==31 SHALL move the block to RUN and set init_done=1; the clear sequence is exactly 32 writes on 32 consecutive edges.
REQ-007 In CLEAR, alu_ready and mem_ready SHALL be 0, and valid inputs SHALL be ignored.
REQ-008 In RUN, a handshake SHALL complete when valid&&ready; ready SHALL NOT depend on the same requester's own data or rd.
REQ-009 In RUN, with exactly one valid requester, that requester SHALL be granted (ready=1).
REQ-010 In RUN, with both requesters valid, exactly one SHALL be granted according to REQ-021/REQ-022; the loser's ready SHALL be 0, and it must hold valid, rd and data stable.
REQ-011 A granted handshake at edge N SHALL present rf_we=1, rf_rd=rd and rf_inf=data after edge N; the write latency is one cycle.
REQ-012 A cycle with no handshake SHALL produce rf_we=0 after the next edge; rf_rd and rf_inf SHALL hold their previous values.
REQ-013 A handshake with rd==0 SHALL be accepted (ready=1) but SHALL produce rf_we=0 (x0 write suppression).
REQ-014 Throughput SHALL be one write per cycle; back-to-back grants carry no bubble.
REQ-015 If valid deasserts without a handshake, there SHALL be no effect; requests are never queued internally.

Reset
REQ-016 While reset=1 at an edge, the block SHALL set state=CLEAR, cnt=0, rf_we=0, rf_rd=0, rf_inf=0, init_done=0, and the round-robin pointer to favour ALU.
REQ-017 While reset=1, alu_ready and mem_ready SHALL be 0.
REQ-018 Reset asserted mid-RUN or mid-CLEAR SHALL drop any in-flight write, because rf_we=0 after the reset edge.
REQ-019 After reset, the clear sequence SHALL restart from cnt=0.
REQ-020 The first clear write (rd=0) SHALL appear after the first edge with reset=0.

Configuration
REQ-021 With WB_ROUND_ROBIN_EN defined, on a conflict the requester not granted at the most recent conflict SHALL win. The pointer SHALL update only on conflict grants, and the first conflict after reset SHALL go to ALU.
REQ-022 Without WB_ROUND_ROBIN_EN, a conflict SHALL always grant MEM (fixed priority), and no pointer register SHALL exist.

Verification
REQ-023 Reset for 2 cycles, then release with CLEAR_VALUE=32'hDEAD_BEEF: the bench observes rf_we=1 for 32 edges, rf_rd 0..31, rf_inf=0 for rd 0 and DEADBEEF otherwise, and init_done=1 after the 32nd edge.
REQ-024 In RUN, drive alu_valid=1, alu_rd=5, alu_data=32'h1234: alu_ready=1 the same cycle, then rf_we=1, rf_rd=5, rf_inf=0x1234 after the edge.
REQ-025 In RUN, drive both valid for 4 cycles, held until accepted (alu rd=1, mem rd=2): with the macro, grants alternate ALU,MEM,ALU,MEM; without it, MEM,MEM,MEM,MEM and alu_ready stays 0.
REQ-026 Drive mem_valid=1, mem_rd=0, mem_data=32'hFFFF_FFFF: mem_ready=1, and rf_we=0 the next cycle.
REQ-027 Assert reset in the cycle of an ALU handshake to rd=7: rf_we=0 after the edge, init_done=0, and the clear sequence restarts at rd 0.
REQ-028 Drive alu_valid=1 during CLEAR: alu_ready=0 throughout; the first grant comes in the cycle after init_done=1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Writeback-port arbiter for a two-source register file (ALU results and
// load data).
//
// After reset the block first runs a clear sequence. It writes x0 with zero
// and x1..x31 with CLEAR_VALUE on 32 consecutive edges, and then raises
// init_done. After that it arbitrates between the two writeback requesters
// and issues at most one register-file write per cycle, with one cycle of
// latency. Writes to x0 are accepted but never reach the register file.
//
// Configuration macro:
//   WB_ROUND_ROBIN_EN  defined   -> conflicts alternate between ALU and MEM,
//                                   and the first conflict after reset goes
//                                   to the ALU.
//                      undefined -> conflicts always go to MEM. No pointer
//                                   register exists in this build.
//
// Parameters:
//   CLEAR_VALUE  value written to x1..x31 during the clear sequence
//
// Ports:
//   clock      in   1  rising-edge clock
//   reset      in   1  synchronous, active-high reset
//   alu_valid  in   1  ALU writeback request
//   alu_rd     in   5  ALU destination register
//   alu_data   in  32  ALU result
//   alu_ready  out  1  ALU request accepted this cycle (combinational)
//   mem_valid  in   1  load writeback request
//   mem_rd     in   5  load destination register
//   mem_data   in  32  load data
//   mem_ready  out  1  load request accepted this cycle (combinational)
//   rf_we      out  1  register-file write enable (registered)
//   rf_rd      out  5  register-file write index (registered)
//   rf_inf     out 32  register-file write data (registered)
//   init_done  out  1  clear sequence finished (registered)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_inf,
    output logic        init_done
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic        rf_we_r;
    logic [4:0]  rf_rd_r;
    logic [31:0] rf_inf_r;
    logic        init_done_r;

    logic        run_s;
    logic        conflict_s;
    logic        alu_pri_s;
    logic        alu_ready_s;
    logic        mem_ready_s;
    logic        alu_hs_s;
    logic        mem_hs_s;

`ifdef WB_ROUND_ROBIN_EN
    // 1 means the ALU wins the next conflict.
    logic        rr_alu_r;
`endif

    // Conflict priority source: round-robin pointer or fixed MEM priority.
    always_comb begin
`ifdef WB_ROUND_ROBIN_EN
        alu_pri_s = rr_alu_r;
`else
        alu_pri_s = 1'b0;
`endif
    end

    // Grant logic. Ready depends only on the valids, the state and the
    // pointer, and never on either requester's rd or data.
    always_comb begin
        run_s       = (state_r == ST_RUN) && !reset;
        conflict_s  = alu_valid && mem_valid;
        alu_ready_s = 1'b0;
        mem_ready_s = 1'b0;
        if (run_s) begin
            if (conflict_s) begin
                alu_ready_s = alu_pri_s;
                mem_ready_s = !alu_pri_s;
            end else begin
                alu_ready_s = alu_valid;
                mem_ready_s = mem_valid;
            end
        end else begin
            alu_ready_s = 1'b0;
            mem_ready_s = 1'b0;
        end
        alu_hs_s = alu_valid && alu_ready_s;
        mem_hs_s = mem_valid && mem_ready_s;
    end

    // Clear/run state machine and registered register-file write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_CLEAR;
            cnt_r       <= 5'd0;
            rf_we_r     <= 1'b0;
            rf_rd_r     <= 5'd0;
            rf_inf_r    <= 32'h0000_0000;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    rf_we_r  <= 1'b1;
                    rf_rd_r  <= cnt_r;
                    rf_inf_r <= (cnt_r == 5'd0) ? 32'h0000_0000 : CLEAR_VALUE;
                    cnt_r    <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r     <= ST_CLEAR;
                        init_done_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Writes to x0 are accepted but suppressed. Index and
                    // data keep their previous values in that case.
                    if (alu_hs_s) begin
                        rf_we_r <= (alu_rd != 5'd0);
                        if (alu_rd != 5'd0) begin
                            rf_rd_r  <= alu_rd;
                            rf_inf_r <= alu_data;
                        end else begin
                            rf_rd_r  <= rf_rd_r;
                            rf_inf_r <= rf_inf_r;
                        end
                    end else if (mem_hs_s) begin
                        rf_we_r <= (mem_rd != 5'd0);
                        if (mem_rd != 5'd0) begin
                            rf_rd_r  <= mem_rd;
                            rf_inf_r <= mem_data;
                        end else begin
                            rf_rd_r  <= rf_rd_r;
                            rf_inf_r <= rf_inf_r;
                        end
                    end else begin
                        rf_we_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    cnt_r       <= 5'd0;
                    rf_we_r     <= 1'b0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_ROUND_ROBIN_EN
    // Round-robin pointer. It moves only when a conflict is resolved, and
    // then points at the requester that lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_alu_r <= 1'b1;
        end else if (run_s && conflict_s) begin
            rr_alu_r <= mem_ready_s;
        end else begin
            rr_alu_r <= rr_alu_r;
        end
    end
`endif

    assign alu_ready = alu_ready_s;
    assign mem_ready = mem_ready_s;
    assign rf_we     = rf_we_r;
    assign rf_rd     = rf_rd_r;
    assign rf_inf    = rf_inf_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Self-checking bench for wb_port_arbiter, built with CLEAR_VALUE=DEADBEEF.
// Expected values are hand-computed. Rows that exercise arbitration
// conflicts follow the WB_ROUND_ROBIN_EN build option.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam logic [31:0] CV = 32'hDEAD_BEEF;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_inf;
    logic        init_done;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(.CLEAR_VALUE(CV)) dut (
        .clock     (clock),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_inf    (rf_inf),
        .init_done (init_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        ear;
        logic        emr;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] einf;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                                input logic ear, input logic emr,
                                input logic ewe, input logic [4:0] erd, input logic [31:0] einf);
        vec_t v;
        v.av = av; v.ard = ard; v.adata = adata;
        v.mv = mv; v.mrd = mrd; v.mdata = mdata;
        v.ear = ear; v.emr = emr;
        v.ewe = ewe; v.erd = erd; v.einf = einf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Follow one full clear sequence starting at the first edge with reset=0.
    task automatic run_clear();
        for (int k = 0; k < 32; k++) begin
            tick();
            check("clr_we", {31'd0, rf_we}, 32'd1);
            check("clr_rd", {27'd0, rf_rd}, k);
            check("clr_inf", rf_inf, (k == 0) ? 32'h0000_0000 : CV);
            check("clr_init_done", {31'd0, init_done}, (k == 31) ? 32'd1 : 32'd0);
            if (k < 31) begin
                #3;
                check("clr_alu_ready", {31'd0, alu_ready}, 32'd0);
                check("clr_mem_ready", {31'd0, mem_ready}, 32'd0);
            end
        end
    endtask

    initial begin
        // Directed table for the RUN phase.
        tbl[0]  = mk(1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5,  32'h0000_1234);
        tbl[1]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd5,  32'h0000_1234);
        tbl[2]  = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd5, 32'h0000_1234);
        tbl[3]  = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd3, 32'h3333_0003, 1'b0, 1'b1, 1'b1, 5'd3, 32'h3333_0003);
        tbl[4]  = mk(1'b1, 5'd31, 32'h1F1F_1F1F, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd31, 32'h1F1F_1F1F);
        tbl[5]  = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd4, 32'h0000_0044, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0044);
        tbl[6]  = mk(1'b1, 5'd0,  32'h0000_5555, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd4,  32'h0000_0044);
        tbl[7]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd4,  32'h0000_0044);
`ifdef WB_ROUND_ROBIN_EN
        tbl[8]  = mk(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_00A1);
        tbl[9]  = mk(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0000_00B2);
        tbl[10] = mk(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_00A1);
        tbl[11] = mk(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0000_00B2);
        tbl[12] = mk(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_00A1);
        tbl[13] = mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 1'b0, 5'd1, 32'h0000_00A1);
`else
        for (int i = 8; i < 13; i++)
            tbl[i] = mk(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0000_00B2);
        tbl[13] = mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 1'b0, 5'd2, 32'h0000_00B2);
`endif

        // Reset for two cycles, with an ALU request already pending.
        reset     = 1'b1;
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'h0000_AAAA;
        mem_valid = 1'b0;
        mem_rd    = 5'd0;
        mem_data  = 32'h0;
        tick();
        tick();
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_rd", {27'd0, rf_rd}, 32'd0);
        check("rst_inf", rf_inf, 32'h0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        #3;
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        reset = 1'b0;

        // Clear sequence. The held ALU request is granted only once
        // init_done is high.
        run_clear();
        #3;
        check("first_grant_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        check("first_grant_we", {31'd0, rf_we}, 32'd1);
        check("first_grant_rd", {27'd0, rf_rd}, 32'd9);
        check("first_grant_inf", rf_inf, 32'h0000_AAAA);

        // Table-driven RUN-phase vectors.
        for (int i = 0; i < 14; i++) begin
            alu_valid = tbl[i].av;
            alu_rd    = tbl[i].ard;
            alu_data  = tbl[i].adata;
            mem_valid = tbl[i].mv;
            mem_rd    = tbl[i].mrd;
            mem_data  = tbl[i].mdata;
            #3;
            check($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, tbl[i].ear});
            check($sformatf("v%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, tbl[i].emr});
            tick();
            check($sformatf("v%0d_we", i), {31'd0, rf_we}, {31'd0, tbl[i].ewe});
            check($sformatf("v%0d_rd", i), {27'd0, rf_rd}, {27'd0, tbl[i].erd});
            check($sformatf("v%0d_inf", i), rf_inf, tbl[i].einf);
        end

        // Reset arriving in the same cycle as an ALU handshake to x7.
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 32'h0000_0077;
        reset     = 1'b1;
        #3;
        check("rst_hs_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        check("rst_hs_we", {31'd0, rf_we}, 32'd0);
        check("rst_hs_init_done", {31'd0, init_done}, 32'd0);
        check("rst_hs_rd", {27'd0, rf_rd}, 32'd0);
        reset     = 1'b0;
        alu_valid = 1'b0;

        // A few clear writes, then reset again in the middle of the clear.
        for (int k = 0; k < 5; k++) begin
            tick();
            check("pclr_we", {31'd0, rf_we}, 32'd1);
            check("pclr_rd", {27'd0, rf_rd}, k);
        end
        reset = 1'b1;
        tick();
        check("mid_clr_rst_we", {31'd0, rf_we}, 32'd0);
        check("mid_clr_rst_rd", {27'd0, rf_rd}, 32'd0);
        reset = 1'b0;
        run_clear();

        // The first conflict after reset goes to the ALU with round-robin
        // enabled, and to MEM otherwise.
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'h0000_00A1;
        mem_valid = 1'b1;
        mem_rd    = 5'd2;
        mem_data  = 32'h0000_00B2;
        #3;
`ifdef WB_ROUND_ROBIN_EN
        check("post_rst_conf_alu_ready", {31'd0, alu_ready}, 32'd1);
        check("post_rst_conf_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();
        check("post_rst_conf_rd", {27'd0, rf_rd}, 32'd1);
`else
        check("post_rst_conf_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("post_rst_conf_mem_ready", {31'd0, mem_ready}, 32'd1);
        tick();
        check("post_rst_conf_rd", {27'd0, rf_rd}, 32'd2);
`endif
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
